// File: rtl/esp_tx_scheduler.sv
// -----------------------------------------------------------------------------
// esp_tx_scheduler
//   Sequences 16-bit frames into the ESP8266 SPI transmitter using a
//   spi_start / spi_data / spi_stop level handshake. Two producers
//   (req0: heart-rate samples, req1: status/commands) are arbitrated
//   round-robin into a shared circular FIFO. After each frame an idle gap
//   is inserted. A frame whose spi_stop edge never arrives is dropped after
//   a timeout, and that event sets a sticky error flag.
//
// Ports
//   HCLK, HRESET              clock, synchronous active-high reset
//   req0_valid/data/ready     producer 0 valid/ready handshake (16-bit word)
//   req1_valid/data/ready     producer 1 valid/ready handshake (16-bit word)
//   spi_data, spi_start       frame word and level request to the SPI master
//   spi_stop                  frame-done level from the SPI master (already
//                             synchronized to HCLK; its rising edge is used)
//   clr_err                   clears err_timeout
//   busy                      FSM not idle or FIFO not empty
//   fifo_count                number of occupied FIFO entries
//   err_timeout               sticky flag: a frame was dropped on timeout
// -----------------------------------------------------------------------------
module esp_tx_scheduler #(
  parameter int FIFO_DEPTH     = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              HCLK,
  input  logic                              HRESET,
  input  logic                              req0_valid,
  input  logic [15:0]                       req0_data,
  output logic                              req0_ready,
  input  logic                              req1_valid,
  input  logic [15:0]                       req1_data,
  output logic                              req1_ready,
  output logic [15:0]                       spi_data,
  output logic                              spi_start,
  input  logic                              spi_stop,
  input  logic                              clr_err,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            stop_q;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]     spi_data_q, spi_data_d;
  logic            spi_start_q, spi_start_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic            full_s;
  logic            empty_s;
  logic            acc0_s;
  logic            acc1_s;
  logic            push_s;
  logic            pop_s;
  logic [15:0]     push_data_s;
  logic            stop_rise_s;
  logic            err_set_s;

  // Full is taken from the registered count only: a pop in the same cycle
  // does not reopen the inputs (no bypass path).
  assign full_s  = (count_q == CW'(FIFO_DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});

  assign req0_ready = ~full_s & (~req1_valid | ~rr_ptr_q);
  assign req1_ready = ~full_s & (~req0_valid |  rr_ptr_q);

  // The ready equations already make the two accepts exclusive; the extra
  // qualifier keeps at most one push per cycle explicit.
  assign acc0_s      = req0_valid & req0_ready;
  assign acc1_s      = req1_valid & req1_ready & ~acc0_s;
  assign push_s      = acc0_s | acc1_s;
  assign push_data_s = acc0_s ? req0_data : req1_data;
  assign pop_s       = (state_q == S_LOAD);

  // A stop level already high when ACTIVE is entered produces no edge.
  assign stop_rise_s = spi_stop & ~stop_q;

  assign spi_data    = spi_data_q;
  assign spi_start   = spi_start_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;
  assign err_timeout = err_q;

  // FIFO pointer/count and round-robin next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // The side just served loses the next tie.
    if (acc0_s) begin
      rr_ptr_d = 1'b1;
    end else if (acc1_s) begin
      rr_ptr_d = 1'b0;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Frame sequencing FSM: next state, frame outputs and counters
  always_comb begin
    state_d     = state_q;
    spi_start_d = spi_start_q;
    spi_data_d  = spi_data_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    err_set_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        spi_data_d  = mem_q[rd_ptr_q];
        spi_start_d = 1'b1;
        tmo_cnt_d   = {TW{1'b0}};
        state_d     = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (stop_rise_s) begin
          spi_start_d = 1'b0;
          gap_cnt_d   = {GW{1'b0}};
          state_d     = S_GAP;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Frame is abandoned; the FIFO head was already consumed in LOAD.
          spi_start_d = 1'b0;
          gap_cnt_d   = {GW{1'b0}};
          err_set_s   = 1'b1;
          state_d     = S_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        spi_start_d = 1'b0;
      end
    endcase
  end

  // Sticky error (a new timeout wins over clr_err) and registered busy
  always_comb begin
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    busy_d = (state_d != S_IDLE) | (count_d != {CW{1'b0}});
  end

  // Control and output registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      rr_ptr_q    <= 1'b0;
      stop_q      <= 1'b0;
      tmo_cnt_q   <= {TW{1'b0}};
      gap_cnt_q   <= {GW{1'b0}};
      spi_data_q  <= 16'h0000;
      spi_start_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      stop_q      <= spi_stop;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      spi_data_q  <= spi_data_d;
      spi_start_q <= spi_start_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked by count
  always_ff @(posedge HCLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

endmodule

// File: tb/tb_esp_tx_scheduler.sv
module tb_esp_tx_scheduler;

  localparam int DEPTH = 8;
  localparam int GAP   = 16;
  localparam int TMO   = 32;

  logic        HCLK;
  logic        HRESET;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic [15:0] spi_data;
  logic        spi_start;
  logic        spi_stop;
  logic        clr_err;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];

  esp_tx_scheduler #(
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .spi_data    (spi_data),
    .spi_start   (spi_start),
    .spi_stop    (spi_stop),
    .clr_err     (clr_err),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .err_timeout (err_timeout)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [15:0] sb_pop();
    if (sb_q.size() != 0) return sb_q.pop_front();
    else return 16'hxxxx;
  endfunction

  // Offer one word on a producer port; scoreboard records it on handshake.
  task automatic push(input int port, input logic [15:0] d);
    int n = 0;
    if (port == 0) begin req0_valid = 1'b1; req0_data = d; end
    else begin req1_valid = 1'b1; req1_data = d; end
    #1;
    while (((port == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("push_ready", (port == 0) ? req0_ready : req1_ready, 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sb_q.push_back(d);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (spi_start !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    check(tag, spi_start, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check("idle", busy, 32'd0);
  endtask

  // Check the frame word against the scoreboard, then complete it with a stop edge.
  task automatic do_frame(input int delay);
    wait_start("frame_start");
    check("frame_data", spi_data, sb_pop());
    repeat (delay) step();
    spi_stop = 1'b1;
    step();
    spi_stop = 1'b0;
    check("frame_stop_fall", spi_start, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] d0;
    logic [15:0] d1;

    HRESET = 1'b1; req0_valid = 1'b0; req0_data = 16'h0; req1_valid = 1'b0;
    req1_data = 16'h0; spi_stop = 1'b0; clr_err = 1'b0;
    step();
    step();
    HRESET = 1'b0;
    check("rst_start", spi_start, 32'd0);
    check("rst_data", spi_data, 32'h0);
    check("rst_count", fifo_count, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_err", err_timeout, 32'd0);

    // T3: continuous contention alternates, req0 first after reset
    d0 = 16'h0001; d1 = 16'h1001;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = d0; req1_data = d1;
    sb_q.push_back(16'h0001); sb_q.push_back(16'h1001);
    sb_q.push_back(16'h0002); sb_q.push_back(16'h1002);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("arb_ready0", req0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("arb_ready1", req1_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      if (i % 2 == 0) d0 = d0 + 16'd1; else d1 = d1 + 16'd1;
      req0_data = d0; req1_data = d1;
      if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
    end
    for (int i = 0; i < 4; i++) do_frame(3);
    wait_idle();

    // T2: single frame latency, stop response and inter-frame gap
    req0_valid = 1'b1; req0_data = 16'hA5A5;
    #1;
    check("t2_ready", req0_ready, 32'd1);
    step();
    req0_valid = 1'b0;
    sb_q.push_back(16'hA5A5);
    check("t2_count", fifo_count, 32'd1);
    check("t2_busy", busy, 32'd1);
    check("t2_start_n0", spi_start, 32'd0);
    step();
    check("t2_start_n1", spi_start, 32'd0);
    step();
    check("t2_start_n2", spi_start, 32'd1);
    check("t2_data", spi_data, sb_pop());
    repeat (9) step();
    check("t2_start_hold", spi_start, 32'd1);
    spi_stop = 1'b1;
    step();
    spi_stop = 1'b0;
    check("t2_start_fall", spi_start, 32'd0);
    check("t2_data_hold", spi_data, 32'hA5A5);
    req0_valid = 1'b1; req0_data = 16'h5A5A;
    #1;
    step();
    req0_valid = 1'b0;
    sb_q.push_back(16'h5A5A);
    n = 0;
    while (spi_start !== 1'b1 && n < 60) begin step(); n++; end
    check("t2_gap_len", n, GAP + 1);
    do_frame(0);
    wait_idle();

    // T6: stop already high across LOAD must not complete the frame
    spi_stop = 1'b1;
    step();
    push(0, 16'h6666);
    wait_start("t6_start");
    check("t6_data", spi_data, sb_pop());
    repeat (5) step();
    check("t6_stale_hold", spi_start, 32'd1);
    spi_stop = 1'b0;
    step();
    check("t6_low_hold", spi_start, 32'd1);
    spi_stop = 1'b1;
    step();
    spi_stop = 1'b0;
    check("t6_complete", spi_start, 32'd0);
    wait_idle();

    // T5: timeout, error flag, clear, and set-beats-clear
    push(0, 16'h7777);
    push(0, 16'h8888);
    wait_start("t5_start1");
    check("t5_data1", spi_data, sb_pop());
    n = 0;
    while (spi_start === 1'b1 && n < 100) begin step(); n++; end
    check("t5_tmo_len", n, TMO);
    check("t5_err_set", err_timeout, 32'd1);
    wait_start("t5_start2");
    check("t5_data2", spi_data, sb_pop());
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t5_err_clr", err_timeout, 32'd0);
    repeat (30) step();
    check("t5_before_tmo", spi_start, 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t5_tmo2_fall", spi_start, 32'd0);
    check("t5_set_wins", err_timeout, 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t5_err_clr2", err_timeout, 32'd0);
    wait_idle();

    // T4: fill the FIFO with the first frame stalled in flight
    for (int i = 0; i < DEPTH + 1; i++) push(1, 16'h4000 + 16'(i));
    req1_valid = 1'b1; req1_data = 16'h4000 + 16'(DEPTH + 1);
    #1;
    check("t4_full_count", fifo_count, DEPTH);
    check("t4_full_ready1", req1_ready, 32'd0);
    check("t4_full_ready0", req0_ready, 32'd0);
    repeat (3) step();
    check("t4_full_count2", fifo_count, DEPTH);
    check("t4_full_ready1b", req1_ready, 32'd0);
    check("t4_inflight", spi_start, 32'd1);
    do_frame(0);
    n = 0;
    while (req1_ready !== 1'b1 && n < 60) begin step(); n++; end
    check("t4_reopen", req1_ready, 32'd1);
    step();
    req1_valid = 1'b0;
    sb_q.push_back(16'h4000 + 16'(DEPTH + 1));
    for (int i = 0; i < DEPTH + 1; i++) do_frame(2);
    wait_idle();
    check("t4_sb_empty", sb_q.size(), 32'd0);

    // T1: reset in the middle of an active frame with err set
    push(0, 16'h1111);
    push(0, 16'h2222);
    wait_start("t1_start1");
    check("t1_data1", spi_data, sb_pop());
    n = 0;
    while (spi_start === 1'b1 && n < 100) begin step(); n++; end
    check("t1_err", err_timeout, 32'd1);
    wait_start("t1_start2");
    check("t1_data2", spi_data, sb_pop());
    repeat (3) step();
    HRESET = 1'b1;
    step();
    step();
    HRESET = 1'b0;
    check("t1_start", spi_start, 32'd0);
    check("t1_count", fifo_count, 32'd0);
    check("t1_err_rst", err_timeout, 32'd0);
    check("t1_busy", busy, 32'd0);
    check("t1_data_rst", spi_data, 32'h0);
    sb_q.delete();
    repeat (5) step();
    check("t1_stay_idle", spi_start, 32'd0);
    check("t1_stay_busy", busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
